board_sequencer: RTL and testbench
==================================

# board_sequencer

Sequences all writes to the 64-cell board store and arbitrates its single RAM port between two requesters: the setup placer, which writes one piece, and the move command from the turn controller (capture/die/trade). After each write it hands the changed cells to the drawing block one at a time using a req/done handshake. It sits between the turn controller and the board RAM/VGA redraw path.

## Interface
- CELL_W, 6, bits per board cell: {team, 5-bit unit}; 000000 blank, 111111 impassable
- GRID, 8, cells per row/column; cell address = {y, x} (6 bits)
- clk  in  1  system clock, all state on posedge
- resetn  in  1  synchronous, active-low reset
- mv_req  in  1  move request; hold high until mv_ack
- mv_src_x, mv_src_y, mv_dst_x, mv_dst_y  in  3 each  move source/destination
- mv_cmd  in  2  00 capture, 01 die, 10 trade, 11 reserved
- mv_ack  out  1  one-cycle pulse: move finished
- set_req  in  1  placement request; hold high until set_ack
- set_x, set_y  in  3 each  placement cell
- set_piece  in  6  value to write
- set_ack  out  1  one-cycle pulse: placement finished
- ram_addr  out  6  board RAM address
- ram_we  out  1  write strobe
- ram_wdata  out  6  write data
- ram_rdata  in  6  read data, valid exactly one cycle after ram_addr is presented with ram_we=0
- draw_req  out  1  redraw request
- draw_x, draw_y  out  3 each  cell to redraw, stable while draw_req is high
- draw_done  in  1  drawing block finished current cell
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse together with mv_ack when the move is rejected

## Operation
- States: IDLE, RD_SRC, RD_WAIT, WR_DST, WR_SRC, SET_WR, DRAW_DST, DRAW_SRC, DONE.
- In IDLE, requests are sampled every cycle. If both are high, mv_req wins; set_req waits. Coordinates, command and piece are latched at acceptance. Inputs are ignored after that.
- Capture (00): RD_SRC (addr=src, we=0) -> RD_WAIT (latch ram_rdata) -> WR_DST (we=1, addr=dst, data=latched piece) -> WR_SRC (we=1, addr=src, data=000000) -> DRAW_DST -> DRAW_SRC -> DONE.
- Die (01): WR_SRC -> DRAW_SRC -> DONE. The destination is untouched.
- Trade (10): WR_DST (data 000000) -> WR_SRC (data 000000) -> DRAW_DST -> DRAW_SRC -> DONE.
- Reserved cmd (11), or any cmd with src==dst: go straight to DONE with err=1. No RAM write and no draw.
- Placement: SET_WR (we=1, addr={set_y,set_x}, data=set_piece) -> DRAW_SRC (with the set cell) -> DONE.
- DRAW_x states: draw_req=1 and draw_x/y = the cell. Leave the state on the cycle draw_done is sampled high.
- DONE: pulse mv_ack or set_ack (whichever op is active) for one cycle, then go to IDLE.
- ram_we is high only in WR_DST, WR_SRC and SET_WR.

## Timing
- Reset: state IDLE, and every output is 0 (ram_addr=0, ram_wdata=0, draw_x/y=0). This applies mid-operation too: the operation is abandoned, draw_req drops immediately, and writes already done remain.
- The requester must drop req on the cycle after the ack. A req still high in IDLE is treated as a new request.
- Latency runs from the IDLE cycle where the req is sampled (cycle 0) to the ack cycle, with draw_done tied high:
  - capture = 7
  - trade = 5
  - die = 3
  - placement = 3
  - rejected = 1
- Each cycle draw_done stays low adds one cycle.
- draw_done while draw_req is low is ignored.
- No RAM read/write overlaps: exactly one access per cycle.
- Coordinates wrap naturally within 3 bits; address is {y,x} with no arithmetic.

## Test plan
- Capture (3,4)->(3,5), cell(3,4)=0_00110, draw_done=1:
  - RAM[43]=0_00110, then RAM[35]=000000.
  - draw (3,5) then (3,4).
  - mv_ack at cycle 7, err=0.
- Trade (0,0)->(1,0), draw_done delayed 4 cycles per cell: both cells become 000000 and mv_ack arrives at cycle 11.
- mv_req and set_req rise in the same cycle: the move completes and acks first. The placement is accepted on the next IDLE cycle and set_ack follows 3 cycles later.
- Rejected moves:
  - mv_cmd=11: err and mv_ack in cycle 1, ram_we never high, draw_req never high.
  - capture src=dst=(2,2): same result.
- resetn low during DRAW_DST of a capture: next cycle busy=0, draw_req=0 and all outputs 0. A new placement then completes normally.
- Placement (7,7) piece 1_00111: RAM[63]=100111, draw (7,7), set_ack at cycle 3.

Source files
------------

// File: rtl/board_sequencer_if.sv
// board_sequencer_if: move/placement handshakes, board RAM port,
// redraw handshake, busy/err status.
//   master: used by board_sequencer (drives acks, RAM port, draw_req)
//   slave : environment side (requesters, RAM, drawing block)
interface board_sequencer_if #(
  parameter int CELL_W = 6,
  parameter int GRID   = 8
);
  localparam int XW = $clog2(GRID);

  logic              mv_req;
  logic [XW-1:0]     mv_src_x;
  logic [XW-1:0]     mv_src_y;
  logic [XW-1:0]     mv_dst_x;
  logic [XW-1:0]     mv_dst_y;
  logic [1:0]        mv_cmd;
  logic              mv_ack;
  logic              set_req;
  logic [XW-1:0]     set_x;
  logic [XW-1:0]     set_y;
  logic [CELL_W-1:0] set_piece;
  logic              set_ack;
  logic [2*XW-1:0]   ram_addr;
  logic              ram_we;
  logic [CELL_W-1:0] ram_wdata;
  logic [CELL_W-1:0] ram_rdata;
  logic              draw_req;
  logic [XW-1:0]     draw_x;
  logic [XW-1:0]     draw_y;
  logic              draw_done;
  logic              busy;
  logic              err;

  modport master (
    input  mv_req, mv_src_x, mv_src_y,
    input  mv_dst_x, mv_dst_y, mv_cmd,
    output mv_ack,
    input  set_req, set_x, set_y, set_piece,
    output set_ack,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata,
    output draw_req, draw_x, draw_y,
    input  draw_done,
    output busy, err
  );

  modport slave (
    output mv_req, mv_src_x, mv_src_y,
    output mv_dst_x, mv_dst_y, mv_cmd,
    input  mv_ack,
    output set_req, set_x, set_y, set_piece,
    input  set_ack,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata,
    input  draw_req, draw_x, draw_y,
    output draw_done,
    input  busy, err
  );
endinterface

// File: rtl/board_sequencer.sv
// board_sequencer: serialises board RAM writes for moves and
// placements, then hands changed cells to the drawing block.
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : board_sequencer_if.master (requests, RAM, draw)
module board_sequencer #(
  parameter int CELL_W = 6,
  parameter int GRID   = 8
) (
  input logic               clk,
  input logic               resetn,
  board_sequencer_if.master bus
);
  localparam int XW = $clog2(GRID);
  localparam int AW = 2 * XW;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RD_SRC   = 4'd1;
  localparam logic [3:0] S_RD_WAIT  = 4'd2;
  localparam logic [3:0] S_WR_DST   = 4'd3;
  localparam logic [3:0] S_WR_SRC   = 4'd4;
  localparam logic [3:0] S_SET_WR   = 4'd5;
  localparam logic [3:0] S_DRAW_DST = 4'd6;
  localparam logic [3:0] S_DRAW_SRC = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam logic [1:0] C_CAP   = 2'b00;
  localparam logic [1:0] C_DIE   = 2'b01;
  localparam logic [1:0] C_TRADE = 2'b10;
  localparam logic [1:0] C_RSV   = 2'b11;

  logic [3:0]        state;
  logic              is_mv;
  logic              rej;
  logic [1:0]        cmd;
  logic [AW-1:0]     src;
  logic [AW-1:0]     dst;
  logic [CELL_W-1:0] piece;

  logic [AW-1:0] req_src;
  logic [AW-1:0] req_dst;

  assign req_src = {bus.mv_src_y, bus.mv_src_x};
  assign req_dst = {bus.mv_dst_y, bus.mv_dst_x};

  // src doubles as the placement cell so DRAW_SRC
  // serves both moves and placements.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      is_mv <= 1'b0;
      rej   <= 1'b0;
      cmd   <= '0;
      src   <= '0;
      dst   <= '0;
      piece <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.mv_req) begin
            is_mv <= 1'b1;
            cmd   <= bus.mv_cmd;
            src   <= req_src;
            dst   <= req_dst;
            rej   <= 1'b0;
            if (bus.mv_cmd == C_RSV ||
                req_src == req_dst) begin
              rej   <= 1'b1;
              state <= S_DONE;
            end else begin
              unique case (bus.mv_cmd)
                C_CAP:   state <= S_RD_SRC;
                C_DIE:   state <= S_WR_SRC;
                C_TRADE: state <= S_WR_DST;
                default: state <= S_DONE;
              endcase
            end
          end else if (bus.set_req) begin
            is_mv <= 1'b0;
            rej   <= 1'b0;
            src   <= {bus.set_y, bus.set_x};
            piece <= bus.set_piece;
            state <= S_SET_WR;
          end
        end
        S_RD_SRC:  state <= S_RD_WAIT;
        S_RD_WAIT: begin
          piece <= bus.ram_rdata;
          state <= S_WR_DST;
        end
        S_WR_DST:  state <= S_WR_SRC;
        S_WR_SRC: begin
          if (cmd == C_DIE) state <= S_DRAW_SRC;
          else              state <= S_DRAW_DST;
        end
        S_SET_WR:  state <= S_DRAW_SRC;
        S_DRAW_DST: begin
          if (bus.draw_done) state <= S_DRAW_SRC;
        end
        S_DRAW_SRC: begin
          if (bus.draw_done) state <= S_DONE;
        end
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mv_ack    = 1'b0;
    bus.set_ack   = 1'b0;
    bus.err       = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.draw_req  = 1'b0;
    bus.draw_x    = '0;
    bus.draw_y    = '0;
    bus.busy      = (state != S_IDLE);
    unique case (state)
      S_RD_SRC: bus.ram_addr = src;
      S_WR_DST: begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = dst;
        // trade blanks both cells
        if (cmd == C_CAP) bus.ram_wdata = piece;
      end
      S_WR_SRC: begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = src;
      end
      S_SET_WR: begin
        bus.ram_we    = 1'b1;
        bus.ram_addr  = src;
        bus.ram_wdata = piece;
      end
      S_DRAW_DST: begin
        bus.draw_req = 1'b1;
        bus.draw_x   = dst[XW-1:0];
        bus.draw_y   = dst[AW-1:XW];
      end
      S_DRAW_SRC: begin
        bus.draw_req = 1'b1;
        bus.draw_x   = src[XW-1:0];
        bus.draw_y   = src[AW-1:XW];
      end
      S_DONE: begin
        bus.mv_ack  = is_mv;
        bus.set_ack = ~is_mv;
        bus.err     = rej;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_board_sequencer.sv
// tb_board_sequencer: randomized and directed stimulus checked
// against an effect-level model of board writes, draws and acks.
module tb_board_sequencer;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  board_sequencer_if bus ();

  board_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  // board RAM: registered read, one-cycle latency
  logic [5:0] mem [64];
  logic       mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 6'd0;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // drawing block: done on the dlat-th cycle of draw_req,
  // random noise on draw_done while draw_req is low
  int   dlat = 1;
  int   dcnt = 0;
  logic noise = 1'b0;
  always @(posedge clk) begin
    noise <= 1'($urandom_range(0, 1));
    if (!bus.draw_req || bus.draw_done) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end
  always_comb begin
    bus.draw_done = noise;
    if (bus.draw_req) bus.draw_done = (dcnt >= dlat - 1);
  end

  // model: expected effects of each accepted request
  logic [5:0] board [64];
  logic [5:0] wa_q [$];
  logic [5:0] wd_q [$];
  logic [5:0] dr_q [$];
  int         ack_cyc_q [$];
  bit         ack_mv_q [$];
  bit         ack_err_q [$];
  int         wlo_q [$];
  int         whi_q [$];

  task automatic push_ack(input int start, input int lat,
                          input bit mv, input bit e,
                          output int endc);
    endc = start + lat;
    ack_cyc_q.push_back(endc);
    ack_mv_q.push_back(mv);
    ack_err_q.push_back(e);
    wlo_q.push_back(start);
    whi_q.push_back(endc);
  endtask

  task automatic model_move(input int start,
                            input logic [1:0] c,
                            input logic [2:0] sx, sy, dx, dy,
                            output int endc);
    logic [5:0] s, d;
    bit e;
    int lat;
    s = {sy, sx};
    d = {dy, dx};
    e = (c == 2'b11) || (s == d);
    lat = 1;
    if (!e && c == 2'b00) begin
      wa_q.push_back(d); wd_q.push_back(board[s]);
      wa_q.push_back(s); wd_q.push_back(6'd0);
      dr_q.push_back(d); dr_q.push_back(s);
      board[d] = board[s];
      board[s] = 6'd0;
      lat = 7 + 2 * (dlat - 1);
    end else if (!e && c == 2'b01) begin
      wa_q.push_back(s); wd_q.push_back(6'd0);
      dr_q.push_back(s);
      board[s] = 6'd0;
      lat = 3 + (dlat - 1);
    end else if (!e) begin
      wa_q.push_back(d); wd_q.push_back(6'd0);
      wa_q.push_back(s); wd_q.push_back(6'd0);
      dr_q.push_back(d); dr_q.push_back(s);
      board[d] = 6'd0;
      board[s] = 6'd0;
      lat = 5 + 2 * (dlat - 1);
    end
    push_ack(start, lat, 1'b1, e, endc);
  endtask

  task automatic model_set(input int start,
                           input logic [2:0] x, y,
                           input logic [5:0] pc,
                           output int endc);
    logic [5:0] a;
    a = {y, x};
    wa_q.push_back(a); wd_q.push_back(pc);
    dr_q.push_back(a);
    board[a] = pc;
    push_ack(start, 3 + (dlat - 1), 1'b0, 1'b0, endc);
  endtask

  // per-cycle compare against the model
  bit eb;
  always @(negedge clk) begin
    eb = 1'b0;
    foreach (wlo_q[i])
      if (cyc > wlo_q[i] && cyc <= whi_q[i]) eb = 1'b1;
    chk("busy", 32'(bus.busy), 32'(eb));
    if (bus.ram_we) begin
      if (wa_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.ram_we), 0);
      end else begin
        chk("wr_addr", 32'(bus.ram_addr), 32'(wa_q[0]));
        chk("wr_data", 32'(bus.ram_wdata), 32'(wd_q[0]));
        void'(wa_q.pop_front());
        void'(wd_q.pop_front());
      end
    end
    if (bus.draw_req) begin
      if (dr_q.size() == 0) begin
        chk("unexpected_draw", 32'(bus.draw_req), 0);
      end else begin
        chk("draw_cell", 32'({bus.draw_y, bus.draw_x}),
            32'(dr_q[0]));
        if (bus.draw_done) void'(dr_q.pop_front());
      end
    end
    if (bus.mv_ack || bus.set_ack) begin
      if (ack_cyc_q.size() == 0) begin
        chk("unexpected_ack",
            32'(bus.mv_ack | bus.set_ack), 0);
      end else begin
        chk("ack_cycle", cyc, ack_cyc_q[0]);
        chk("ack_mv", 32'(bus.mv_ack), 32'(ack_mv_q[0]));
        chk("ack_set", 32'(bus.set_ack), 32'(!ack_mv_q[0]));
        chk("ack_err", 32'(bus.err), 32'(ack_err_q[0]));
        void'(ack_cyc_q.pop_front());
        void'(ack_mv_q.pop_front());
        void'(ack_err_q.pop_front());
      end
    end else if (bus.err) begin
      chk("err_without_ack", 32'(bus.err), 0);
    end
  end

  int op_start, last_mv, last_set;
  bit last_err;

  task automatic do_op(input bit do_mv, input bit do_set,
                       input logic [1:0] c,
                       input logic [2:0] sx, sy, dx, dy,
                       input logic [2:0] px, py,
                       input logic [5:0] pc,
                       input int dl);
    int me, se, n;
    bit mp, sp, mh, sh;
    @(posedge clk); #1;
    dlat = dl;
    op_start = cyc;
    me = cyc;
    se = cyc;
    if (do_mv) model_move(cyc, c, sx, sy, dx, dy, me);
    if (do_set) model_set(do_mv ? me + 1 : cyc, px, py, pc, se);
    bus.mv_cmd = c;
    bus.mv_src_x = sx; bus.mv_src_y = sy;
    bus.mv_dst_x = dx; bus.mv_dst_y = dy;
    bus.set_x = px; bus.set_y = py;
    bus.set_piece = pc;
    bus.mv_req = do_mv;
    bus.set_req = do_set;
    mp = do_mv; sp = do_set; n = 0;
    while ((mp || sp) && n < 400) begin
      @(negedge clk);
      mh = mp && bus.mv_ack;
      sh = sp && bus.set_ack;
      if (mh) begin last_mv = cyc; last_err = bus.err; end
      if (sh) last_set = cyc;
      @(posedge clk); #1;
      if (mh) begin bus.mv_req = 1'b0; mp = 1'b0; end
      if (sh) begin bus.set_req = 1'b0; sp = 1'b0; end
      n++;
    end
    if (mp || sp) chk("op_timeout", 32'({mp, sp}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int me;
    int r, dl;
    logic [1:0] c;
    logic [2:0] sx, sy, dx, dy, px, py;
    logic [5:0] pc;
    resetn = 1'b0;
    mem_clr = 1'b1;
    bus.mv_req = 1'b0; bus.set_req = 1'b0;
    bus.mv_cmd = 2'b00;
    bus.mv_src_x = 3'd0; bus.mv_src_y = 3'd0;
    bus.mv_dst_x = 3'd0; bus.mv_dst_y = 3'd0;
    bus.set_x = 3'd0; bus.set_y = 3'd0;
    bus.set_piece = 6'd0;
    for (int i = 0; i < 64; i++) board[i] = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_we", 32'(bus.ram_we), 0);
    chk("rst_addr", 32'(bus.ram_addr), 0);
    chk("rst_wdata", 32'(bus.ram_wdata), 0);
    chk("rst_draw", 32'({bus.draw_req, bus.draw_x, bus.draw_y}), 0);
    chk("rst_acks", 32'({bus.mv_ack, bus.set_ack, bus.err}), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    mem_clr = 1'b0;

    // place (3,4) then capture (3,4)->(3,5)
    do_op(0, 1, 2'b00, 0, 0, 0, 0, 3, 4, 6'b0_00110, 1);
    chk("set_lat", last_set - op_start, 3);
    do_op(1, 0, 2'b00, 3, 4, 3, 5, 0, 0, 6'd0, 1);
    chk("cap_lat", last_mv - op_start, 7);
    chk("cap_err", 32'(last_err), 0);
    chk("cap_dst_cell", 32'(mem[43]), 32'(6'b0_00110));
    chk("cap_src_cell", 32'(mem[35]), 0);

    // trade (0,0)->(1,0), draw_done on 4th cycle
    do_op(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 6'b0_01010, 1);
    do_op(0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 6'b1_10001, 1);
    do_op(1, 0, 2'b10, 0, 0, 1, 0, 0, 0, 6'd0, 4);
    chk("trade_lat", last_mv - op_start, 11);
    chk("trade_cells", 32'({mem[0], mem[1]}), 0);

    // die at (5,2)
    do_op(0, 1, 2'b00, 0, 0, 0, 0, 5, 2, 6'b0_00011, 1);
    do_op(1, 0, 2'b01, 5, 2, 6, 6, 0, 0, 6'd0, 1);
    chk("die_lat", last_mv - op_start, 3);
    chk("die_cell", 32'(mem[21]), 0);

    // simultaneous move and placement
    do_op(1, 1, 2'b00, 3, 5, 4, 5, 4, 4, 6'b1_00001, 1);
    chk("both_mv_lat", last_mv - op_start, 7);
    chk("both_set_gap", last_set - last_mv, 4);

    // rejected moves
    do_op(1, 0, 2'b11, 1, 1, 2, 2, 0, 0, 6'd0, 1);
    chk("rsv_lat", last_mv - op_start, 1);
    chk("rsv_err", 32'(last_err), 1);
    do_op(1, 0, 2'b00, 2, 2, 2, 2, 0, 0, 6'd0, 1);
    chk("same_lat", last_mv - op_start, 1);
    chk("same_err", 32'(last_err), 1);

    // reset during DRAW_DST of a capture (6,1)->(6,2)
    do_op(0, 1, 2'b00, 0, 0, 0, 0, 6, 1, 6'b1_01100, 1);
    @(posedge clk); #1;
    dlat = 4;
    model_move(cyc, 2'b00, 6, 1, 6, 2, me);
    bus.mv_cmd = 2'b00;
    bus.mv_src_x = 3'd6; bus.mv_src_y = 3'd1;
    bus.mv_dst_x = 3'd6; bus.mv_dst_y = 3'd2;
    bus.mv_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_in_draw", 32'(bus.draw_req), 1);
    resetn = 1'b0;
    bus.mv_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_writes_done", wa_q.size(), 0);
    dr_q.delete();
    ack_cyc_q.delete(); ack_mv_q.delete(); ack_err_q.delete();
    wlo_q.delete(); whi_q.delete();
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_draw", 32'({bus.draw_req, bus.draw_x, bus.draw_y}), 0);
    chk("mid_rst_ram", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 0);
    chk("mid_rst_acks", 32'({bus.mv_ack, bus.set_ack, bus.err}), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("mid_rst_dst_kept", 32'(mem[22]), 32'(6'b1_01100));
    chk("mid_rst_src_kept", 32'(mem[14]), 0);

    // placement (7,7)
    do_op(0, 1, 2'b00, 0, 0, 0, 0, 7, 7, 6'b1_00111, 1);
    chk("p77_lat", last_set - op_start, 3);
    chk("p77_cell", 32'(mem[63]), 32'(6'b1_00111));

    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      dl = $urandom_range(1, 3);
      c  = 2'($urandom_range(0, 3));
      sx = 3'($urandom_range(0, 7));
      sy = 3'($urandom_range(0, 7));
      dx = 3'($urandom_range(0, 7));
      dy = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin dx = sx; dy = sy; end
      px = 3'($urandom_range(0, 7));
      py = 3'($urandom_range(0, 7));
      pc = 6'($urandom_range(0, 63));
      if (r < 4)      do_op(0, 1, c, sx, sy, dx, dy, px, py, pc, dl);
      else if (r < 9) do_op(1, 0, c, sx, sy, dx, dy, px, py, pc, dl);
      else            do_op(1, 1, c, sx, sy, dx, dy, px, py, pc, dl);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("left_writes", wa_q.size(), 0);
    chk("left_draws", dr_q.size(), 0);
    chk("left_acks", ack_cyc_q.size(), 0);
    for (int i = 0; i < 64; i++)
      chk($sformatf("board_%0d", i), 32'(mem[i]), 32'(board[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
